// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one synchronous single-port framebuffer SRAM
// between the VGA burst fetcher (priority) and the CPU single-word port.
// A saturating wait counter lets a starving CPU beat video at arbitration.
// Optional build macro VGA_ARB_STATS_EN adds the cpu_stall_max output.
module vga_fb_arbiter #(
  parameter int unsigned AW       = 19,
  parameter int unsigned DW       = 24,
  parameter int unsigned BURST    = 16,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0]   cpu_stall_max
`endif
);

  localparam int unsigned BW = $clog2(BURST + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 2);

  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] wait_cnt;
  logic          cpu_pend;
  logic          cpu_win;
  logic          vid_win;

  // Arbitration decision taken in IDLE, applied at the next edge
  always_comb begin
    cpu_pend = cpu_req & ~cpu_ack;
    cpu_win  = 1'b0;
    vid_win  = 1'b0;
    if (state == IDLE) begin
      cpu_win = cpu_pend & ((wait_cnt >= WW'(MAX_WAIT)) | ~vid_req);
      vid_win = ~cpu_win & vid_req;
    end
  end

  // Main FSM driving the registered SRAM, grant and ack outputs
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      vid_gnt   <= 1'b0;
      cpu_ack   <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      vid_gnt <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_win) begin
            state     <= CPU;
            mem_cs    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end else if (vid_win) begin
            state    <= VID;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= vid_addr;
            vid_gnt  <= 1'b1;
            beat_cnt <= '0;
          end
        end
        VID: begin
          if (beat_cnt == BW'(BURST - 1)) begin
            state  <= IDLE;
            mem_cs <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
            mem_addr <= mem_addr + AW'(1);
          end
        end
        CPU: begin
          state   <= IDLE;
          mem_cs  <= 1'b0;
          mem_we  <= 1'b0;
          cpu_ack <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Read data strobe for video, one cycle behind each burst beat
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      vid_rvalid <= 1'b0;
    end else begin
      vid_rvalid <= mem_cs & ~mem_we & (state == VID);
    end
  end

  // CPU starvation counter; the CPU cycle itself is not counted as waiting
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      wait_cnt <= '0;
    end else if (cpu_win) begin
      wait_cnt <= '0;
    end else if (cpu_pend && (state != CPU) && (wait_cnt < WW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Read data is forced to zero outside its valid cycle
  always_comb begin
    vid_rdata = vid_rvalid ? mem_rdata : '0;
    cpu_rdata = cpu_ack ? mem_rdata : '0;
  end

`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_cnt;

  // Longest CPU request-to-grant wait since reset, saturating
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      stall_cnt     <= '0;
      cpu_stall_max <= '0;
    end else if (cpu_win) begin
      stall_cnt <= '0;
      if (stall_cnt > cpu_stall_max) begin
        cpu_stall_max <= stall_cnt;
      end
    end else if (cpu_pend && (state != CPU) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter (BURST=16, MAX_WAIT=64):
// directed vector table, reset-mid-burst sequence and randomized traffic
// checked against a transaction-level arbitration model.
module tb_vga_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 24;
  localparam int BURST = 16;
  localparam int MAX_WAIT = 64;
  localparam int BOUND = MAX_WAIT + BURST + 2;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_tests = 0;
  int n_fail = 0;

  vga_fb_arbiter #(
    .AW(AW),
    .DW(DW),
    .BURST(BURST),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_gnt   (vid_gnt),
    .vid_rvalid(vid_rvalid),
    .vid_rdata (vid_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 pixel_clk = ~pixel_clk;

  // SRAM model: written words kept sparse, unwritten words read a fixed pattern
  logic [DW-1:0] ram [logic [AW-1:0]];

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (ram.exists(a)) return ram[a];
    return {5'h15, a};
  endfunction

  // Synchronous read port: data the cycle after a read select
  always @(posedge pixel_clk) begin
    if (mem_cs && !mem_we) mem_rdata <= rd(mem_addr);
  end

  // Advance one cycle; sample point is 1 time unit after the edge.
  // A write selected in the cycle now starting is committed to the model here.
  task automatic tick();
    @(posedge pixel_clk);
    #1;
    if (mem_cs && mem_we) ram[mem_addr] = mem_wdata;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " mem_cs"},     32'(mem_cs), 32'(0));
    chk({nm, " mem_we"},     32'(mem_we), 32'(0));
    chk({nm, " mem_addr"},   32'(mem_addr), 32'(0));
    chk({nm, " mem_wdata"},  32'(mem_wdata), 32'(0));
    chk({nm, " vid_gnt"},    32'(vid_gnt), 32'(0));
    chk({nm, " vid_rvalid"}, 32'(vid_rvalid), 32'(0));
    chk({nm, " vid_rdata"},  32'(vid_rdata), 32'(0));
    chk({nm, " cpu_ack"},    32'(cpu_ack), 32'(0));
    chk({nm, " cpu_rdata"},  32'(cpu_rdata), 32'(0));
  endtask

  // Directed vector: requests rise together in cycle 0; vs/cs give the cycle
  // of the first video beat / the CPU access (-1 = none expected)
  typedef struct {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwdata;
    int            vs;
    int            cs;
    logic [DW-1:0] crdata;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    logic          in_vid, is_cpu, e_rv;
    logic [AW-1:0] e_addr;
    string         nm;
    tick();
    vid_req   = v.vreq;
    vid_addr  = v.vaddr;
    cpu_req   = v.creq;
    cpu_we    = v.cwe;
    cpu_addr  = v.caddr;
    cpu_wdata = v.cwdata;
    for (int c = 1; c <= 22; c++) begin
      tick();
      nm = $sformatf("vec%0d c%0d", idx, c);
      in_vid = (v.vs >= 0) && (c >= v.vs) && (c < v.vs + BURST);
      is_cpu = (v.cs >= 0) && (c == v.cs);
      e_rv   = (v.vs >= 0) && (c >= v.vs + 1) && (c < v.vs + BURST + 1);
      chk({nm, " mem_cs"}, 32'(mem_cs), 32'(in_vid | is_cpu));
      chk({nm, " vid_gnt"}, 32'(vid_gnt), 32'((v.vs >= 0) && (c == v.vs)));
      chk({nm, " vid_rvalid"}, 32'(vid_rvalid), 32'(e_rv));
      chk({nm, " cpu_ack"}, 32'(cpu_ack), 32'((v.cs >= 0) && (c == v.cs + 1)));
      if (in_vid) begin
        e_addr = v.vaddr + AW'(c - v.vs);
        chk({nm, " vid mem_we"}, 32'(mem_we), 32'(0));
        chk({nm, " vid mem_addr"}, 32'(mem_addr), 32'(e_addr));
      end
      if (is_cpu) begin
        chk({nm, " cpu mem_we"}, 32'(mem_we), 32'(v.cwe));
        chk({nm, " cpu mem_addr"}, 32'(mem_addr), 32'(v.caddr));
        if (v.cwe) chk({nm, " cpu mem_wdata"}, 32'(mem_wdata), 32'(v.cwdata));
      end
      if (e_rv) begin
        e_addr = v.vaddr + AW'(c - v.vs - 1);
        chk({nm, " vid_rdata"}, 32'(vid_rdata), 32'(rd(e_addr)));
      end
      if ((v.cs >= 0) && (c == v.cs + 1) && !v.cwe)
        chk({nm, " cpu_rdata"}, 32'(cpu_rdata), 32'(v.crdata));
      if (vid_gnt) vid_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom);
    return AW'($urandom_range(0, 63));
  endfunction

  vec_t vecs [8];

  // Randomized-traffic model state
  int            vid_left, cyc, c_rise, wt;
  logic [AW-1:0] vid_nxt;
  logic          rv_exp, ack_exp, ack_rd, cur_ack, drop_next;
  logic [DW-1:0] rv_dat, ack_dat;
  logic          p_cs, p_vreq, p_creq, p_cack, p_cwe;
  logic [AW-1:0] p_vaddr, p_caddr;
  logic [DW-1:0] p_cwdata;
  logic          vbeat, cgnt, e_gnt;

  initial begin
    vecs[0] = '{1'b1, 19'h00100, 1'b0, 1'b0, 19'h0, 24'h0, 1, -1, 24'h0};
    vecs[1] = '{1'b1, 19'h7FFF8, 1'b0, 1'b0, 19'h0, 24'h0, 1, -1, 24'h0};
    vecs[2] = '{1'b0, 19'h0, 1'b1, 1'b1, 19'h12345, 24'hABCDEF, -1, 1, 24'h0};
    vecs[3] = '{1'b0, 19'h0, 1'b1, 1'b0, 19'h12345, 24'h0, -1, 1, 24'hABCDEF};
    vecs[4] = '{1'b1, 19'h00040, 1'b1, 1'b0, 19'h12345, 24'h0, 1, 18, 24'hABCDEF};
    vecs[5] = '{1'b1, 19'h00040, 1'b1, 1'b1, 19'h00045, 24'h5A5A5A, 1, 18, 24'h0};
    vecs[6] = '{1'b0, 19'h0, 1'b1, 1'b0, 19'h00045, 24'h0, -1, 1, 24'h5A5A5A};
    vecs[7] = '{1'b0, 19'h0, 1'b1, 1'b0, 19'h00200, 24'h0, -1, 1, 24'hA80200};

    pixel_rst = 1'b1;
    vid_req = 1'b0;  vid_addr = '0;
    cpu_req = 1'b0;  cpu_we = 1'b0;  cpu_addr = '0;  cpu_wdata = '0;
    tick();
    tick();
    chk_zero("reset");
    pixel_rst = 1'b0;
    tick();
    chk_zero("post-reset idle");

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while beat 5 of a burst is on the bus
    tick();
    vid_req = 1'b1;
    vid_addr = 19'h00500;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (vid_gnt) vid_req = 1'b0;
    end
    chk("midrst beat5 addr", 32'(mem_addr), 32'(19'h00505));
    pixel_rst = 1'b1;
    tick();
    chk_zero("midrst");
    pixel_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst trailing rvalid", 32'(vid_rvalid), 32'(0));
      chk("midrst mem_cs", 32'(mem_cs), 32'(0));
    end
    run_vec(8, '{1'b1, 19'h00300, 1'b0, 1'b0, 19'h0, 24'h0, 1, -1, 24'h0});

    // Randomized traffic; phase 1 keeps video requesting back-to-back
    vid_left = 0;  cyc = 0;  c_rise = 0;  vid_nxt = '0;
    rv_exp = 1'b0; ack_exp = 1'b0; ack_rd = 1'b0; drop_next = 1'b0;
    rv_dat = '0;   ack_dat = '0;
    p_cs = 1'b0; p_vreq = 1'b0; p_creq = 1'b0; p_cack = 1'b0; p_cwe = 1'b0;
    p_vaddr = '0; p_caddr = '0; p_cwdata = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 2500; n++) begin
        tick();
        cyc++;
        vbeat = 1'b0;
        cgnt  = 1'b0;
        e_gnt = 1'b0;
        if (vid_left > 0) begin
          vbeat = 1'b1;
        end else if (!p_cs) begin
          wt = cyc - 1 - c_rise;
          if (wt > MAX_WAIT) wt = MAX_WAIT;
          if (p_creq && !p_cack && (wt >= MAX_WAIT || !p_vreq)) begin
            cgnt = 1'b1;
          end else if (p_vreq) begin
            vbeat = 1'b1;
            e_gnt = 1'b1;
            vid_left = BURST;
            vid_nxt = p_vaddr;
          end
        end
        chk("rnd mem_cs", 32'(mem_cs), 32'(vbeat | cgnt));
        chk("rnd vid_gnt", 32'(vid_gnt), 32'(e_gnt));
        chk("rnd vid_rvalid", 32'(vid_rvalid), 32'(rv_exp));
        chk("rnd cpu_ack", 32'(cpu_ack), 32'(ack_exp));
        if (rv_exp) chk("rnd vid_rdata", 32'(vid_rdata), 32'(rv_dat));
        if (ack_exp && ack_rd) chk("rnd cpu_rdata", 32'(cpu_rdata), 32'(ack_dat));
        cur_ack = ack_exp;
        rv_exp  = vbeat;
        ack_exp = cgnt;
        if (vbeat) begin
          chk("rnd vid mem_we", 32'(mem_we), 32'(0));
          chk("rnd vid mem_addr", 32'(mem_addr), 32'(vid_nxt));
          rv_dat = rd(vid_nxt);
          vid_nxt = vid_nxt + AW'(1);
          vid_left--;
        end
        if (cgnt) begin
          chk("rnd cpu mem_we", 32'(mem_we), 32'(p_cwe));
          chk("rnd cpu mem_addr", 32'(mem_addr), 32'(p_caddr));
          if (p_cwe) chk("rnd cpu mem_wdata", 32'(mem_wdata), 32'(p_cwdata));
          chk("rnd cpu grant within bound", 32'((cyc - c_rise) <= BOUND), 32'(1));
          ack_rd  = !p_cwe;
          ack_dat = rd(p_caddr);
        end
        p_cs   = vbeat | cgnt;
        p_cack = cur_ack;

        if (e_gnt) begin
          if (ph == 1 || $urandom_range(0, 1) == 1) vid_addr = rnd_addr();
          else vid_req = 1'b0;
        end else if (!vid_req && $urandom_range(0, 5) == 0) begin
          vid_req = 1'b1;
          vid_addr = rnd_addr();
        end

        if (drop_next) begin
          cpu_req = 1'b0;
          drop_next = 1'b0;
        end else if (cpu_req && cur_ack) begin
          if ($urandom_range(0, 1) == 1) cpu_req = 1'b0;
          else drop_next = 1'b1;
        end else if (!cpu_req && $urandom_range(0, 9) == 0) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = AW'($urandom_range(0, 63));
          cpu_wdata = DW'($urandom);
          c_rise    = cyc;
        end

        p_vreq   = vid_req;
        p_vaddr  = vid_addr;
        p_creq   = cpu_req;
        p_cwe    = cpu_we;
        p_caddr  = cpu_addr;
        p_cwdata = cpu_wdata;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
